// File: rtl/axi4_lite_sub_regfile.sv
// AXI4-Lite subordinate backed by a 64-bit register file.
// Independent write/read channels, byte strobes, DECERR outside the window.
module axi4_lite_sub_regfile #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 64,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 4096
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic                AWVALID,
    output logic                AWREADY,
    input  logic [ADDR_W-1:0]   AWADDR,
    input  logic [ID_W-1:0]     AWID,

    input  logic                WVALID,
    output logic                WREADY,
    input  logic [DATA_W-1:0]   WDATA,
    input  logic [DATA_W/8-1:0] WSTRB,

    output logic                BVALID,
    input  logic                BREADY,
    output logic [1:0]          BRESP,
    output logic [ID_W-1:0]     BID,

    input  logic                ARVALID,
    output logic                ARREADY,
    input  logic [ADDR_W-1:0]   ARADDR,
    input  logic [ID_W-1:0]     ARID,

    output logic                RVALID,
    input  logic                RREADY,
    output logic [DATA_W-1:0]   RDATA,
    output logic [1:0]          RRESP,
    output logic [ID_W-1:0]     RID
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WORDS  = MEM_BYTES / 8;
    localparam int IDX_HI = $clog2(MEM_BYTES) - 1;
    localparam int IDX_W  = IDX_HI - 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [ADDR_W-1:0] WIN_LIMIT = ADDR_W'(MEM_BYTES);

    // Storage; deliberately not reset so contents survive ARESET.
    logic [DATA_W-1:0] mem [WORDS];

    // Ready outputs are held low until the first edge out of reset.
    logic              running;

    // One-entry write-address buffer.
    logic              aw_full;
    logic [ADDR_W-1:0] aw_addr;
    logic [ID_W-1:0]   aw_id;

    // One-entry write-data buffer.
    logic              w_full;
    logic [DATA_W-1:0] w_data;
    logic [STRB_W-1:0] w_strb;

    logic              aw_hs;
    logic              w_hs;
    logic              ar_hs;
    logic              b_free;
    logic              commit;
    logic              aw_in_win;
    logic              ar_in_win;
    logic [IDX_W-1:0]  aw_idx;
    logic [IDX_W-1:0]  ar_idx;

    assign AWREADY = running & ~aw_full;
    assign WREADY  = running & ~w_full;
    assign ARREADY = running & (~RVALID | RREADY);

    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & WREADY;
    assign ar_hs   = ARVALID & ARREADY;

    // A commit may reuse the B slot on the edge that retires it.
    assign b_free  = ~BVALID | BREADY;
    assign commit  = aw_full & w_full & b_free;

    assign aw_in_win = (aw_addr < WIN_LIMIT);
    assign ar_in_win = (ARADDR < WIN_LIMIT);

    assign aw_idx = aw_addr[IDX_HI:3];
    assign ar_idx = ARADDR[IDX_HI:3];

    // Ready enable: low during reset, high from the first clean edge.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            running <= 1'b0;
        end else begin
            running <= 1'b1;
        end
    end

    // AW buffer: fill on handshake, drain on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_full <= 1'b0;
            aw_addr <= '0;
            aw_id   <= '0;
        end else if (aw_hs) begin
            aw_full <= 1'b1;
            aw_addr <= AWADDR;
            aw_id   <= AWID;
        end else if (commit) begin
            aw_full <= 1'b0;
        end
    end

    // W buffer: fill on handshake, drain on commit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_full <= 1'b0;
            w_data <= '0;
            w_strb <= '0;
        end else if (w_hs) begin
            w_full <= 1'b1;
            w_data <= WDATA;
            w_strb <= WSTRB;
        end else if (commit) begin
            w_full <= 1'b0;
        end
    end

    // Register-file update: strobed byte lanes, in-window commits only.
    always_ff @(posedge ACLK) begin
        if (!ARESET && commit && aw_in_win) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) begin
                    mem[aw_idx][i*8 +: 8] <= w_data[i*8 +: 8];
                end
            end
        end
    end

    // B channel: load on commit, retire on BREADY.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            BVALID <= 1'b0;
            BRESP  <= RESP_OKAY;
            BID    <= '0;
        end else if (commit) begin
            BVALID <= 1'b1;
            BID    <= aw_id;
            BRESP  <= aw_in_win ? RESP_OKAY : RESP_DECERR;
        end else if (BREADY) begin
            BVALID <= 1'b0;
        end
    end

    // R channel: array read on AR handshake (sees pre-commit contents).
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RESP_OKAY;
            RID    <= '0;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            RID    <= ARID;
            if (ar_in_win) begin
                RDATA <= mem[ar_idx];
                RRESP <= RESP_OKAY;
            end else begin
                RDATA <= '0;
                RRESP <= RESP_DECERR;
            end
        end else if (RREADY) begin
            RVALID <= 1'b0;
        end
    end

endmodule
